// File: rtl/fetch_ctrl.sv
// fetch_ctrl - pipeline control for the fetch stage.
//
// Detects load-use hazards, holds the front end while data memory is busy,
// turns branches resolved in EXE into a single-cycle fetch redirect with
// flush, and remembers a branch that resolves while memory is busy so it
// can be issued on the first idle cycle. Also provides a memory-wait
// watchdog and saturating stall/flush event counters.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   id_valid_i              ID stage holds a real instruction
//   id_src1_i, id_src2_i    ID source registers
//   id_two_src_i            ID instruction reads id_src2_i as a register
//   exe_dest_i              EXE destination register
//   exe_mem_read_i          EXE instruction is a load
//   br_resolve_i            branch in EXE resolved this cycle
//   br_cond_i               resolved branch is taken
//   br_imm_i                word offset relative to current fetch PC
//   mem_busy_i              data memory not ready
//   br_taken_o              fetch selects PC + br_offset_o*4
//   br_offset_o             word offset to fetch (0 when not taken)
//   freeze_o                hold PC and IF/ID
//   flush_o                 clear IF/ID and ID/EXE to NOP
//   id_bubble_o             insert NOP into ID/EXE, hold ID
//   mem_hold_o              freeze EXE/MEM/WB registers
//   mem_timeout_o           sticky watchdog flag
//   stall_cnt_o             saturating count of freeze cycles
//   flush_cnt_o             saturating count of flush cycles
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_RUN      | memory ready; redirects, load-use stalls act normally
// S_MEM_WAIT | memory busy on the previous cycle; wait counter is running

module fetch_ctrl #(
    parameter int unsigned WORD_LEN = 32,
    parameter int unsigned REG_ADDR = 5,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                id_valid_i,
    input  logic [REG_ADDR-1:0] id_src1_i,
    input  logic [REG_ADDR-1:0] id_src2_i,
    input  logic                id_two_src_i,
    input  logic [REG_ADDR-1:0] exe_dest_i,
    input  logic                exe_mem_read_i,
    input  logic                br_resolve_i,
    input  logic                br_cond_i,
    input  logic [WORD_LEN-1:0] br_imm_i,
    input  logic                mem_busy_i,
    output logic                br_taken_o,
    output logic [WORD_LEN-1:0] br_offset_o,
    output logic                freeze_o,
    output logic                flush_o,
    output logic                id_bubble_o,
    output logic                mem_hold_o,
    output logic                mem_timeout_o,
    output logic [15:0]         stall_cnt_o,
    output logic [15:0]         flush_cnt_o
);

    typedef enum logic {
        S_RUN      = 1'b0,
        S_MEM_WAIT = 1'b1
    } state_e;

    localparam logic [15:0] WAIT_LIM = 16'(TIMEOUT);
    localparam logic [15:0] WAIT_PRE = 16'(TIMEOUT - 1);
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    state_e                state_q, state_d;
    logic                  pend_v_q, pend_v_d;
    logic [WORD_LEN-1:0]   pend_off_q, pend_off_d;
    logic [15:0]           wait_cnt_q, wait_cnt_d;
    logic                  timeout_q, timeout_d;
    logic [15:0]           stall_cnt_q, stall_cnt_d;
    logic [15:0]           flush_cnt_q, flush_cnt_d;

    logic lu;
    logic bl;

    assign lu = id_valid_i & exe_mem_read_i & (exe_dest_i != '0)
              & ((exe_dest_i == id_src1_i) | (id_two_src_i & (exe_dest_i == id_src2_i)));
    assign bl = br_resolve_i & br_cond_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_RUN;
            pend_v_q    <= 1'b0;
            pend_off_q  <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_v_q    <= pend_v_d;
            pend_off_q  <= pend_off_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        pend_v_d    = pend_v_q;
        pend_off_d  = pend_off_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (mem_busy_i) begin
            state_d = S_MEM_WAIT;
            // Frozen EXE keeps presenting the same branch, so recapturing is harmless.
            if (bl) begin
                pend_v_d   = 1'b1;
                pend_off_d = br_imm_i;
            end
            if (wait_cnt_q != WAIT_LIM) begin
                wait_cnt_d = wait_cnt_q + 16'd1;
            end
            if (wait_cnt_q >= WAIT_PRE) begin
                timeout_d = 1'b1;
            end
        end else begin
            state_d = S_RUN;
            // Any redirect this cycle consumes the pending branch.
            pend_v_d = 1'b0;
            if (state_q == S_MEM_WAIT) begin
                wait_cnt_d = '0;
            end
        end

        if (freeze_o && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (flush_o && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    // Output logic; everything is held at zero while reset is asserted.
    always_comb begin
        br_taken_o  = 1'b0;
        br_offset_o = '0;
        freeze_o    = 1'b0;
        flush_o     = 1'b0;
        id_bubble_o = 1'b0;
        mem_hold_o  = 1'b0;
        if (rst_ni) begin
            if (mem_busy_i) begin
                freeze_o   = 1'b1;
                mem_hold_o = 1'b1;
            end else if (bl || pend_v_q) begin
                // Live branch wins; it squashes the ID instruction so load-use is moot.
                br_taken_o  = 1'b1;
                flush_o     = 1'b1;
                br_offset_o = bl ? br_imm_i : pend_off_q;
            end else if (lu) begin
                freeze_o    = 1'b1;
                id_bubble_o = 1'b1;
            end
        end
    end

    assign mem_timeout_o = rst_ni & timeout_q;
    assign stall_cnt_o   = rst_ni ? stall_cnt_q : 16'd0;
    assign flush_cnt_o   = rst_ni ? flush_cnt_q : 16'd0;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_src1, id_src2;
    logic        id_two_src;
    logic [4:0]  exe_dest;
    logic        exe_mem_read;
    logic        br_resolve, br_cond;
    logic [31:0] br_imm;
    logic        mem_busy;
    logic        br_taken;
    logic [31:0] br_offset;
    logic        freeze, flush, id_bubble, mem_hold, mem_timeout;
    logic [15:0] stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        bt;
        logic [31:0] off;
        logic        frz, fl, bub, hold, to;
        logic [15:0] sc, fc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    fetch_ctrl #(.WORD_LEN(32), .REG_ADDR(5), .TIMEOUT(4)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .id_valid_i     (id_valid),
        .id_src1_i      (id_src1),
        .id_src2_i      (id_src2),
        .id_two_src_i   (id_two_src),
        .exe_dest_i     (exe_dest),
        .exe_mem_read_i (exe_mem_read),
        .br_resolve_i   (br_resolve),
        .br_cond_i      (br_cond),
        .br_imm_i       (br_imm),
        .mem_busy_i     (mem_busy),
        .br_taken_o     (br_taken),
        .br_offset_o    (br_offset),
        .freeze_o       (freeze),
        .flush_o        (flush),
        .id_bubble_o    (id_bubble),
        .mem_hold_o     (mem_hold),
        .mem_timeout_o  (mem_timeout),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: every negedge with an outstanding expectation, compare all outputs.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                checks++;
                if (br_taken !== mon_e.bt || br_offset !== mon_e.off || freeze !== mon_e.frz ||
                    flush !== mon_e.fl || id_bubble !== mon_e.bub || mem_hold !== mon_e.hold ||
                    mem_timeout !== mon_e.to || stall_cnt !== mon_e.sc || flush_cnt !== mon_e.fc) begin
                    failures++;
                    $display("FAIL %s: got bt=%0b off=%h frz=%0b fl=%0b bub=%0b hold=%0b to=%0b sc=%0d fc=%0d ; want bt=%0b off=%h frz=%0b fl=%0b bub=%0b hold=%0b to=%0b sc=%0d fc=%0d",
                             mon_e.name, br_taken, br_offset, freeze, flush, id_bubble, mem_hold,
                             mem_timeout, stall_cnt, flush_cnt, mon_e.bt, mon_e.off, mon_e.frz,
                             mon_e.fl, mon_e.bub, mon_e.hold, mon_e.to, mon_e.sc, mon_e.fc);
                end
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge.
    task automatic cyc(input logic rst, input logic v, input logic [4:0] s1, input logic [4:0] s2,
                       input logic two, input logic [4:0] ed, input logic mr, input logic br,
                       input logic bc, input logic [31:0] imm, input logic busy);
        @(posedge clk);
        #1;
        rst_n        = rst;
        id_valid     = v;
        id_src1      = s1;
        id_src2      = s2;
        id_two_src   = two;
        exe_dest     = ed;
        exe_mem_read = mr;
        br_resolve   = br;
        br_cond      = bc;
        br_imm       = imm;
        mem_busy     = busy;
    endtask

    task automatic push_exp(input string name, input logic bt, input logic [31:0] off,
                            input logic frz, input logic fl, input logic bub, input logic hold,
                            input logic to, input logic [15:0] sc, input logic [15:0] fc);
        exp_t e;
        e.name = name; e.bt = bt; e.off = off; e.frz = frz; e.fl = fl;
        e.bub = bub; e.hold = hold; e.to = to; e.sc = sc; e.fc = fc;
        exp_q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
        exe_dest = 0; exe_mem_read = 0; br_resolve = 0; br_cond = 0; br_imm = 0; mem_busy = 0;

        //  rst v  s1 s2 two ed mr br bc imm           busy          bt off           frz fl bub hold to sc fc
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0); push_exp("reset",     0, 32'h0,        0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0); push_exp("idle",      0, 32'h0,        0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 3, 0, 0, 3, 1, 0, 0, 32'h0,        0); push_exp("lu_src1",   0, 32'h0,        1, 0, 1, 0, 0, 0, 0);
        cyc(1, 1, 3, 0, 0, 3, 0, 0, 0, 32'h0,        0); push_exp("lu_gone",   0, 32'h0,        0, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 0, 0, 1, 0, 0, 32'h0,        0); push_exp("lu_r0",     0, 32'h0,        0, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, 1, 5, 1, 5, 1, 0, 0, 32'h0,        0); push_exp("lu_src2",   0, 32'h0,        1, 0, 1, 0, 0, 1, 0);
        cyc(1, 1, 1, 5, 0, 5, 1, 0, 0, 32'h0,        0); push_exp("no_src2",   0, 32'h0,        0, 0, 0, 0, 0, 2, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'hFFFFFFFC, 0); push_exp("br_taken",  1, 32'hFFFFFFFC, 0, 1, 0, 0, 0, 2, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFC, 0); push_exp("br_not",    0, 32'h0,        0, 0, 0, 0, 0, 2, 1);
        cyc(1, 1, 3, 0, 0, 3, 1, 1, 1, 32'h10,       0); push_exp("br_lu",     1, 32'h10,       0, 1, 0, 0, 0, 2, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0); push_exp("idle2",     0, 32'h0,        0, 0, 0, 0, 0, 2, 2);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h8,        1); push_exp("busy1",     0, 32'h0,        1, 0, 0, 1, 0, 2, 2);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h8,        1); push_exp("busy2",     0, 32'h0,        1, 0, 0, 1, 0, 3, 2);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h8,        1); push_exp("busy3",     0, 32'h0,        1, 0, 0, 1, 0, 4, 2);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h8,        1); push_exp("busy4",     0, 32'h0,        1, 0, 0, 1, 0, 5, 2);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h8,        0); push_exp("pend_live", 1, 32'h8,        0, 1, 0, 0, 1, 6, 2);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0); push_exp("after",     0, 32'h0,        0, 0, 0, 0, 1, 6, 3);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0); push_exp("once",      0, 32'h0,        0, 0, 0, 0, 1, 6, 3);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h20,       1); push_exp("busy_b",    0, 32'h0,        1, 0, 0, 1, 1, 6, 3);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        1); push_exp("busy_nb",   0, 32'h0,        1, 0, 0, 1, 1, 7, 3);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0); push_exp("pend_only", 1, 32'h20,       0, 1, 0, 0, 1, 8, 3);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0); push_exp("pend_once", 0, 32'h0,        0, 0, 0, 0, 1, 8, 4);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h40,       1); push_exp("busy_c",    0, 32'h0,        1, 0, 0, 1, 1, 8, 4);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h44,       0); push_exp("live_wins", 1, 32'h44,       0, 1, 0, 0, 1, 9, 4);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0); push_exp("idle3",     0, 32'h0,        0, 0, 0, 0, 1, 9, 5);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0); push_exp("reset2",    0, 32'h0,        0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        1); push_exp("wd1",       0, 32'h0,        1, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        1); push_exp("wd2",       0, 32'h0,        1, 0, 0, 1, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        1); push_exp("wd3",       0, 32'h0,        1, 0, 0, 1, 0, 2, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        1); push_exp("wd4",       0, 32'h0,        1, 0, 0, 1, 0, 3, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        1); push_exp("wd5_set",   0, 32'h0,        1, 0, 0, 1, 1, 4, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        1); push_exp("wd6",       0, 32'h0,        1, 0, 0, 1, 1, 5, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0); push_exp("wd_idle",   0, 32'h0,        0, 0, 0, 0, 1, 6, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0); push_exp("wd_sticky", 0, 32'h0,        0, 0, 0, 0, 1, 6, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h8,        1); push_exp("rb_busy",   0, 32'h0,        1, 0, 0, 1, 1, 6, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        1); push_exp("rb_busy2",  0, 32'h0,        1, 0, 0, 1, 1, 7, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        1); push_exp("rst_async", 0, 32'h0,        0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0); push_exp("rel",       0, 32'h0,        0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0); push_exp("rel2",      0, 32'h0,        0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
